// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package interrupt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI
  } intState_t;

  typedef enum logic [1:0] {
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } intSrc_t;

  localparam logic [1:0] PUSH_PCH = 2'd0;
  localparam logic [1:0] PUSH_PCL = 2'd1;
  localparam logic [1:0] PUSH_P   = 2'd2;

endpackage

// File: rtl/nmi_edge_detector.sv
// NMI pin synchronizer, falling-edge detector and pending latch.
module nmi_edge_detector (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic en_i,
  input  logic pin_n_i,
  input  logic ack_i,
  output logic pending_o
);

  logic sync1_q, sync2_q, prev_q;
  logic pending_q, pending_d;
  logic fall;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= pin_n_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Edge capture runs regardless of stall; a fresh edge wins over a same-cycle ack.
  always_comb begin
    pending_d = pending_q;
    if (ack_i && en_i) pending_d = 1'b0;
    if (fall)          pending_d = 1'b1;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// NMI/BRK/IRQ arbitration and the five-cycle interrupt entry sequence.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enableFFs,
  input  logic        nmiPin_n,
  input  logic        irqPin_n,
  input  logic        processStatusRegIFlag,
  input  logic        brkDecoded,
  input  logic        instrBoundary,
  output logic        interruptActive,
  output logic        nmiPending,
  output logic        stackPush,
  output logic [1:0]  pushSel,
  output logic        pushBFlag,
  output logic        vectorFetch,
  output logic [15:0] vectorAddr,
  output logic        setIFlag,
  output logic        nmiAck
);

  intState_t   state_q, state_d;
  intSrc_t     src_q, src_d;
  logic        irqSync1_q, irqSync2_q;
  logic        irqReq;
  logic        stackPushRaw, setIFlagRaw, nmiAckRaw;
  logic [15:0] base;

  nmi_edge_detector u_nmi (
    .clk_i     (clk),
    .nrst_i    (nrst),
    .en_i      (enableFFs),
    .pin_n_i   (nmiPin_n),
    .ack_i     (nmiAck),
    .pending_o (nmiPending)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_IRQ;
      irqSync1_q <= 1'b1;
      irqSync2_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      irqSync1_q <= irqPin_n;
      irqSync2_q <= irqSync1_q;
    end
  end

  assign irqReq = ~irqSync2_q & ~processStatusRegIFlag;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    if (enableFFs) begin
      case (state_q)
        ST_IDLE: begin
          if (instrBoundary && (nmiPending || irqReq || brkDecoded)) begin
            state_d = ST_PUSH_PCH;
            if (nmiPending)      src_d = SRC_NMI;
            else if (brkDecoded) src_d = SRC_BRK;
            else                 src_d = SRC_IRQ;
          end
        end
        ST_PUSH_PCH: state_d = ST_PUSH_PCL;
        ST_PUSH_PCL: state_d = ST_PUSH_P;
        ST_PUSH_P: begin
          // Pending stays set until acked in VEC_LO, so sampling it on leaving
          // PUSH_P catches any NMI seen earlier in the sequence.
          state_d = ST_VEC_LO;
          if (nmiPending) src_d = SRC_NMI;
        end
        ST_VEC_LO: state_d = ST_VEC_HI;
        ST_VEC_HI: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign base = (src_q == SRC_NMI) ? VEC_NMI : VEC_IRQ;

  always_comb begin
    interruptActive = (state_q != ST_IDLE);
    stackPushRaw    = 1'b0;
    pushSel         = PUSH_PCH;
    pushBFlag       = 1'b0;
    vectorFetch     = 1'b0;
    vectorAddr      = VEC_IRQ;
    setIFlagRaw     = 1'b0;
    nmiAckRaw       = 1'b0;
    case (state_q)
      ST_PUSH_PCH: begin
        stackPushRaw = 1'b1;
        pushSel      = PUSH_PCH;
      end
      ST_PUSH_PCL: begin
        stackPushRaw = 1'b1;
        pushSel      = PUSH_PCL;
      end
      ST_PUSH_P: begin
        stackPushRaw = 1'b1;
        pushSel      = PUSH_P;
        pushBFlag    = (src_q == SRC_BRK);
      end
      ST_VEC_LO: begin
        vectorFetch = 1'b1;
        vectorAddr  = base;
        setIFlagRaw = 1'b1;
        nmiAckRaw   = (src_q == SRC_NMI);
      end
      ST_VEC_HI: begin
        vectorFetch = 1'b1;
        vectorAddr  = base + 16'd1;
      end
      default: ;
    endcase
  end

  assign stackPush = stackPushRaw & enableFFs;
  assign setIFlag  = setIFlagRaw & enableFFs;
  assign nmiAck    = nmiAckRaw & enableFFs;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with hand-computed expectations.
module tb_interrupt_sequencer;

  logic        clk, nrst, enableFFs, nmiPin_n, irqPin_n;
  logic        iFlag, brk, bnd;
  logic        interruptActive, nmiPending, stackPush, pushBFlag;
  logic        vectorFetch, setIFlag, nmiAck;
  logic [1:0]  pushSel;
  logic [15:0] vectorAddr;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  string       scn = "";
  logic        seen;

  interrupt_sequencer #(.VEC_NMI(16'hFFFA), .VEC_IRQ(16'hFFFE)) dut (
    .clk                   (clk),
    .nrst                  (nrst),
    .enableFFs             (enableFFs),
    .nmiPin_n              (nmiPin_n),
    .irqPin_n              (irqPin_n),
    .processStatusRegIFlag (iFlag),
    .brkDecoded            (brk),
    .instrBoundary         (bnd),
    .interruptActive       (interruptActive),
    .nmiPending            (nmiPending),
    .stackPush             (stackPush),
    .pushSel               (pushSel),
    .pushBFlag             (pushBFlag),
    .vectorFetch           (vectorFetch),
    .vectorAddr            (vectorAddr),
    .setIFlag              (setIFlag),
    .nmiAck                (nmiAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s got=%0h exp=%0h", scn, tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle();
    chk("act",   interruptActive, 0);
    chk("pend",  nmiPending, 0);
    chk("push",  stackPush, 0);
    chk("sel",   pushSel, 0);
    chk("bflag", pushBFlag, 0);
    chk("fetch", vectorFetch, 0);
    chk("addr",  vectorAddr, 16'hFFFE);
    chk("seti",  setIFlag, 0);
    chk("ack",   nmiAck, 0);
  endtask

  // Called one sample after the edge that entered PUSH_PCH.
  task automatic run_entry(input logic bflag, input logic [15:0] lo,
                           input logic [15:0] hi, input logic ack);
    chk("pch_act",  interruptActive, 1);
    chk("pch_push", stackPush, 1);
    chk("pch_sel",  pushSel, 0);
    tick();
    chk("pcl_push", stackPush, 1);
    chk("pcl_sel",  pushSel, 1);
    tick();
    chk("p_push",   stackPush, 1);
    chk("p_sel",    pushSel, 2);
    chk("p_bflag",  pushBFlag, bflag);
    tick();
    chk("vlo_fetch", vectorFetch, 1);
    chk("vlo_addr",  vectorAddr, lo);
    chk("vlo_seti",  setIFlag, 1);
    chk("vlo_ack",   nmiAck, ack);
    chk("vlo_push",  stackPush, 0);
    tick();
    chk("vhi_fetch", vectorFetch, 1);
    chk("vhi_addr",  vectorAddr, hi);
    chk("vhi_seti",  setIFlag, 0);
    chk("vhi_ack",   nmiAck, 0);
    tick();
    chk("end_act",   interruptActive, 0);
    chk("end_fetch", vectorFetch, 0);
  endtask

  initial begin
    nrst = 1'b0; enableFFs = 1'b1; nmiPin_n = 1'b1; irqPin_n = 1'b1;
    iFlag = 1'b1; brk = 1'b0; bnd = 1'b0;
    repeat (2) tick();
    scn = "reset";
    chk_idle();
    nrst = 1'b1;
    tick();

    scn = "nmi";
    nmiPin_n = 1'b0;
    tick(); tick();
    chk("lat_e2", nmiPending, 0);
    tick();
    chk("lat_e3", nmiPending, 1);
    nmiPin_n = 1'b1;
    repeat (3) tick();
    nmiPin_n = 1'b0;
    repeat (3) tick();
    chk("absorb", nmiPending, 1);
    bnd = 1'b1;
    tick();
    bnd = 1'b0;
    run_entry(1'b0, 16'hFFFA, 16'hFFFB, 1'b1);
    chk("cleared", nmiPending, 0);
    bnd = 1'b1;
    repeat (2) tick();
    chk("once", interruptActive, 0);
    bnd = 1'b0; nmiPin_n = 1'b1;
    repeat (3) tick();

    scn = "irq";
    irqPin_n = 1'b0; iFlag = 1'b1; bnd = 1'b1; seen = 1'b0;
    repeat (20) begin
      tick();
      if (interruptActive) seen = 1'b1;
    end
    chk("masked", seen, 0);
    iFlag = 1'b0;
    tick();
    bnd = 1'b0; irqPin_n = 1'b1; iFlag = 1'b1;
    run_entry(1'b0, 16'hFFFE, 16'hFFFF, 1'b0);

    scn = "brk_irq";
    irqPin_n = 1'b0; iFlag = 1'b0;
    repeat (2) tick();
    brk = 1'b1; bnd = 1'b1;
    tick();
    brk = 1'b0; bnd = 1'b0;
    run_entry(1'b1, 16'hFFFE, 16'hFFFF, 1'b0);

    scn = "nmi_brk_irq";
    nmiPin_n = 1'b0;
    repeat (3) tick();
    brk = 1'b1; bnd = 1'b1;
    tick();
    brk = 1'b0; bnd = 1'b0;
    run_entry(1'b0, 16'hFFFA, 16'hFFFB, 1'b1);
    chk("cleared", nmiPending, 0);
    irqPin_n = 1'b1; iFlag = 1'b1; nmiPin_n = 1'b1;
    repeat (3) tick();

    scn = "hijack";
    nmiPin_n = 1'b0;
    tick();
    brk = 1'b1; bnd = 1'b1;
    tick();
    brk = 1'b0; bnd = 1'b0;
    run_entry(1'b1, 16'hFFFA, 16'hFFFB, 1'b1);
    chk("cleared", nmiPending, 0);
    nmiPin_n = 1'b1;
    repeat (3) tick();

    scn = "stall";
    brk = 1'b1; bnd = 1'b1;
    tick();
    brk = 1'b0; bnd = 1'b0;
    tick();
    enableFFs = 1'b0; nmiPin_n = 1'b0;
    #1;
    chk("push_q", stackPush, 0);
    chk("act", interruptActive, 1);
    repeat (3) tick();
    chk("sel_hold", pushSel, 1);
    chk("push_q3", stackPush, 0);
    chk("pend_set", nmiPending, 1);
    enableFFs = 1'b1;
    #1;
    chk("push_resume", stackPush, 1);
    tick();
    chk("p_sel", pushSel, 2);
    chk("p_bflag", pushBFlag, 1);
    tick();
    chk("vlo_addr", vectorAddr, 16'hFFFA);
    chk("vlo_ack", nmiAck, 1);
    tick();
    chk("vhi_addr", vectorAddr, 16'hFFFB);
    tick();
    chk("end_act", interruptActive, 0);
    chk("cleared", nmiPending, 0);
    nmiPin_n = 1'b1;
    repeat (3) tick();

    scn = "ack_race";
    nmiPin_n = 1'b0;
    repeat (3) tick();
    nmiPin_n = 1'b1;
    repeat (3) tick();
    bnd = 1'b1;
    tick();
    bnd = 1'b0;
    tick();
    nmiPin_n = 1'b0;
    tick(); tick();
    chk("vlo_ack", nmiAck, 1);
    tick();
    chk("pend_kept", nmiPending, 1);
    tick();
    chk("idle", interruptActive, 0);
    nmiPin_n = 1'b1; bnd = 1'b1;
    tick();
    bnd = 1'b0;
    run_entry(1'b0, 16'hFFFA, 16'hFFFB, 1'b1);
    chk("cleared", nmiPending, 0);
    repeat (3) tick();

    scn = "rst_mid";
    brk = 1'b1; bnd = 1'b1;
    tick();
    brk = 1'b0; bnd = 1'b0;
    tick(); tick();
    chk("p_sel", pushSel, 2);
    chk("p_bflag", pushBFlag, 1);
    nrst = 1'b0;
    #1;
    chk_idle();
    tick();
    nrst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
